// File: rtl/seq_mag_cmp_pkg.sv
// seq_mag_cmp_pkg: shared state, result encodings and cascade resolution for seq_mag_cmp
package seq_mag_cmp_pkg;
  typedef enum logic {IDLE, CMP} state_t;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_BOTH = 3'b110;
  // cas is {iagb, iasb, iaeb}; result is {qagb, qasb, qaeb}, 74HC85 truth table with iaeb dominant
  function automatic logic [2:0] cascade_res(input logic [2:0] cas);
    return cas[0] ? RES_EQ :
           cas[2:1] == 2'b10 ? RES_GT :
           cas[2:1] == 2'b01 ? RES_LT :
           cas[2] ? RES_NONE : RES_BOTH;
  endfunction
endpackage

// File: rtl/seq_mag_cmp_if.sv
// seq_mag_cmp_if: request/operand/result bundle of the sequential magnitude comparator
interface seq_mag_cmp_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             iagb;
  logic             iasb;
  logic             iaeb;
  logic             busy;
  logic             done;
  logic             qagb;
  logic             qasb;
  logic             qaeb;
  modport master (output start, a, b, iagb, iasb, iaeb, input busy, done, qagb, qasb, qaeb);
  modport slave  (input start, a, b, iagb, iasb, iaeb, output busy, done, qagb, qasb, qaeb);
endinterface

// File: rtl/seq_mag_cmp_slice_cmp.sv
// slice_cmp: combinational unsigned compare of one SLICE-bit slice
module slice_cmp #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             gt,
  output logic             lt
);
  assign gt = a > b;
  assign lt = a < b;
endmodule

// File: rtl/seq_mag_cmp.sv
// seq_mag_cmp: multi-cycle MSB-slice-first magnitude compare with early exit; SEQ_MAG_CMP_SIGNED_EN selects two's complement operands
module seq_mag_cmp
  import seq_mag_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic          clk,
  input logic          rst,
  seq_mag_cmp_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  if (SLICE < 1 || SLICE > WIDTH || WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("seq_mag_cmp: WIDTH must be a non-zero multiple of SLICE");
  end
  state_t                       state, state_nx;
  logic [IW-1:0]                idx, idx_nx;
  logic [WIDTH-1:0]             a_q, b_q, a_in, b_in;
  logic [NSLICE-1:0][SLICE-1:0] a_v, b_v;
  logic [2:0]                   cas_q, res, res_nx;
  logic                         done, done_nx, load, gt, lt;
`ifdef SEQ_MAG_CMP_SIGNED_EN
  localparam logic [WIDTH-1:0] FLIP = WIDTH'(1) << (WIDTH - 1);
  assign a_in = bus.a ^ FLIP;
  assign b_in = bus.b ^ FLIP;
`else
  assign a_in = bus.a;
  assign b_in = bus.b;
`endif
  assign a_v = a_q;
  assign b_v = b_q;
  slice_cmp #(.SLICE(SLICE)) u_slice (.a(a_v[idx]), .b(b_v[idx]), .gt(gt), .lt(lt));
  // next state: accept in IDLE, walk slices down in CMP until a difference or the last slice
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    res_nx   = res;
    done_nx  = 1'b0;
    load     = 1'b0;
    if (state == IDLE) begin
      if (bus.start) begin
        state_nx = CMP;
        idx_nx   = IW'(NSLICE - 1);
        load     = 1'b1;
      end
    end else if (gt || lt || idx == '0) begin
      state_nx = IDLE;
      done_nx  = 1'b1;
      res_nx   = gt ? RES_GT : lt ? RES_LT : cascade_res(cas_q);
    end else begin
      idx_nx = idx - 1'b1;
    end
  end
  // state, slice index, captured operands and held result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cas_q <= '0;
      res   <= RES_NONE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      res   <= res_nx;
      done  <= done_nx;
      if (load) begin
        a_q   <= a_in;
        b_q   <= b_in;
        cas_q <= {bus.iagb, bus.iasb, bus.iaeb};
      end
    end
  end
  assign bus.busy = state == CMP;
  assign bus.done = done;
  assign {bus.qagb, bus.qasb, bus.qaeb} = res;
endmodule

// File: doc/seq_mag_cmp.md
Name: seq_mag_cmp

Overview:
Parametrised multi-cycle magnitude comparator. It is the sequential successor to the team's 4-bit cascadable comparator.
- Compares two WIDTH-bit operands one SLICE-bit slice per clock, MSB slice first.
- Terminates early at the first differing slice.
- Resolves full equality through 74HC85-style cascade inputs.
- Used wherever wide compares must be time-multiplexed onto a narrow comparator, e.g. threshold checks in counter/timer subsystems.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of SLICE.
- SLICE, 4, bits compared per cycle; 1 <= SLICE <= WIDTH.
- NSLICE, WIDTH/SLICE, derived (localparam), number of slices.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request a compare; sampled only in IDLE.
- A  in  WIDTH  operand A; captured on the accepting edge.
- B  in  WIDTH  operand B; captured on the accepting edge.
- IAGB  in  1  cascade input "A>B" from a less-significant stage; captured with operands.
- IASB  in  1  cascade input "A<B"; captured with operands.
- IAEB  in  1  cascade input "A=B"; captured with operands.
- BUSY  out  1  high while a compare is in progress.
- DONE  out  1  one-cycle pulse: result valid and updated.
- QAGB  out  1  result A>B; registered and held.
- QASB  out  1  result A<B; registered and held.
- QAEB  out  1  result A=B; registered and held.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; BUSY=0, DONE=0, QAGB=QASB=QAEB=0; internal index and operand registers cleared.
- States:
  - IDLE: BUSY=0. START=1 at an edge captures A, B and the cascade inputs, sets idx=NSLICE-1, and moves to CMP.
  - CMP: BUSY=1. At each edge, slice idx of A and B is compared (bits idx*SLICE+SLICE-1 : idx*SLICE).
    - A_slice > B_slice: QAGB/QASB/QAEB=1/0/0, DONE=1, go to IDLE.
    - A_slice < B_slice: 0/1/0, DONE=1, go to IDLE.
    - Equal and idx==0: apply cascade resolution, DONE=1, go to IDLE.
    - Equal and idx>0: idx decrements, stay in CMP.
- Cascade resolution (all slices equal), priority order:
  - IAEB=1 -> 0/0/1.
  - IAGB=1 & IASB=0 -> 1/0/0.
  - IAGB=0 & IASB=1 -> 0/1/0.
  - IAGB=1 & IASB=1 -> 0/0/0.
  - IAGB=0 & IASB=0 -> 1/1/0.
- Latency: with the START edge as edge 0, DONE is high for the cycle following edge k, where k = 1 + (number of leading equal slices). k is in 1..NSLICE.
- Back-to-back: START may be high in the same cycle DONE is high. The FSM is in IDLE then, so the request is accepted.
- DONE is high for exactly one cycle per accepted START.
- Q outputs change only on the edge that raises DONE; otherwise they hold their last value.
- START while BUSY=1 is ignored, not queued.
- A, B and cascade inputs are don't-care except on the accepting edge.
- Reset asserted mid-compare aborts immediately: no DONE, and outputs are forced to reset values.
- WIDTH==SLICE degenerates to a single-cycle compare (k=1).
- Static check: elaboration error if WIDTH % SLICE != 0.

Optional Feature:
- Macro: SEQ_MAG_CMP_SIGNED_EN.
- Defined: operands are two's complement. On capture, bit WIDTH-1 of both A and B is inverted (offset-binary conversion). Slice compares remain unsigned, so the result is a signed compare. Latency rules are unchanged.
- Undefined: purely unsigned compare; no inversion logic is present.

Decomposition:
- Package seq_mag_cmp_pkg holds:
  - state enum {IDLE, CMP};
  - result constants RES_GT=3'b100, RES_LT=3'b010, RES_EQ=3'b001, RES_NONE=3'b000, RES_BOTH=3'b110 (order QAGB,QASB,QAEB);
  - a cascade-resolution function.
- One combinational sub-module, slice_cmp (parameter SLICE; outputs gt, lt), instantiated once and fed by an idx-selected slice mux.

Test Plan (WIDTH=16, SLICE=4 unless stated):
- A=0x1234, B=0x1234, IAEB=1 -> DONE after 4 cycles, Q=0/0/1, BUSY high for 4 cycles.
- A=0x8000, B=0x7FFF (unsigned) -> DONE after 1 cycle, Q=1/0/0. Same operands with SEQ_MAG_CMP_SIGNED_EN -> DONE after 1 cycle, Q=0/1/0.
- A=0x1235, B=0x1236 -> DONE after 4 cycles, Q=0/1/0. A=0x1300, B=0x12FF -> DONE after 2 cycles, Q=1/0/0.
- A=B=0xFFFF with cascade (IAGB,IASB,IAEB) = 100, 010, 110, 000, 111 -> Q = 100, 010, 000, 110, 001 respectively.
- START pulsed on cycles 1 and 2 (second while BUSY) with A=0x0001, B=0x0000 -> exactly one DONE at cycle 5. START held high continuously -> DONE every 5 cycles for equal operands.
- RST asserted on cycle 2 of a 4-slice compare -> BUSY, DONE and Q drop to 0 asynchronously, no DONE follows. A subsequent START completes normally.
